// File: rtl/bist_pkg.sv
// Shared constants for the March C- RAM BIST engine: element indices,
// per-element tables, FSM encoding and data backgrounds.
package bist_pkg;

   localparam int ELEM_W = 3;

   // March C- element indices, in execution order
   localparam logic [ELEM_W-1:0] ELEM_M0 = 3'd0;
   localparam logic [ELEM_W-1:0] ELEM_M1 = 3'd1;
   localparam logic [ELEM_W-1:0] ELEM_M2 = 3'd2;
   localparam logic [ELEM_W-1:0] ELEM_M3 = 3'd3;
   localparam logic [ELEM_W-1:0] ELEM_M4 = 3'd4;
   localparam logic [ELEM_W-1:0] ELEM_M5 = 3'd5;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Single-bit backgrounds, replicated across the data width by users
   localparam logic BG_ZERO = 1'b0;
   localparam logic BG_ONE  = 1'b1;

   // Per-element tables, bit i describes element Mi (bits 6-7 unused).
   // Direction: 1 = descending addresses (M3, M4).
   localparam logic [7:0] ELEM_DOWN        = 8'b0001_1000;
   // Op count: 1 = two ops per address (read then write), 0 = single op.
   localparam logic [7:0] ELEM_TWO_OPS     = 8'b0001_1110;
   // First op kind: 1 = write (only M0), 0 = read.
   localparam logic [7:0] ELEM_FIRST_WRITE = 8'b0000_0001;
   // Background expected by the element's read (1 for M2, M4).
   localparam logic [7:0] ELEM_READ_BG     = {2'b00, BG_ZERO, BG_ONE, BG_ZERO, BG_ONE, BG_ZERO, BG_ZERO};
   // Background written by the element's write (1 for M1, M3).
   localparam logic [7:0] ELEM_WRITE_BG    = {2'b00, BG_ZERO, BG_ZERO, BG_ONE, BG_ZERO, BG_ONE, BG_ZERO};

endpackage

// File: rtl/bist_response_checker.sv
// Read-response checker: registers what each BIST read should return, compares
// the RAM data one cycle later and holds the first failing address/element.
module bist_response_checker
   import bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  rd_valid,
   input  logic [DATA_WIDTH-1:0] rd_expected,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [ELEM_W-1:0]     rd_elem,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [ELEM_W-1:0]     fail_elem
);

   logic                  pend_q, pend_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ELEM_W-1:0]     elem_q, elem_d;
   logic                  fail_q, fail_d;
   logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
   logic [ELEM_W-1:0]     fail_elem_q, fail_elem_d;
   logic                  mismatch;

   // Pipeline the read context and keep only the first mismatch of a run
   always_comb begin
      pend_d      = rd_valid;
      exp_d       = rd_expected;
      addr_d      = rd_addr;
      elem_d      = rd_elem;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      mismatch    = pend_q && (ram_rdata != exp_q);
      if (clear) begin
         pend_d      = 1'b0;
         fail_d      = 1'b0;
         fail_addr_d = '0;
         fail_elem_d = '0;
      end else if (mismatch && !fail_q) begin
         fail_d      = 1'b1;
         fail_addr_d = addr_q;
         fail_elem_d = elem_q;
      end
   end

   // Register update; reset also drops any compare still in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= 1'b0;
         exp_q       <= '0;
         addr_q      <= '0;
         elem_q      <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
      end else begin
         pend_q      <= pend_d;
         exp_q       <= exp_d;
         addr_q      <= addr_d;
         elem_q      <= elem_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
      end
   end

   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;
   assign fail_elem = fail_elem_q;

endmodule

// File: rtl/bist_march_generator.sv
// March C- RAM BIST sequencer: steps through the six elements one RAM op per
// cycle, owns the RAM via bist_mode while busy, and reports the first failure.
module bist_march_generator
   import bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  bist_mode,
   output logic [ADDR_WIDTH-1:0] bist_addr,
   output logic [DATA_WIDTH-1:0] bist_wdata,
   output logic                  bist_we,
   output logic                  bist_re,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [ELEM_W-1:0]     fail_elem
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   logic [1:0]            state_q, state_d;
   logic [ELEM_W-1:0]     elem_q, elem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  op_q, op_d;

   logic                  running;
   logic                  is_write;
   logic                  last_op;
   logic                  terminal;
   logic                  elem_down;
   logic [ELEM_W-1:0]     elem_next;
   logic                  start_accept;

   // Decode the op currently presented and whether it closes an address/element
   always_comb begin
      running      = (state_q == ST_RUN);
      elem_down    = ELEM_DOWN[elem_q];
      is_write     = ELEM_FIRST_WRITE[elem_q] | op_q;
      last_op      = ~ELEM_TWO_OPS[elem_q] | op_q;
      terminal     = elem_down ? (addr_q == '0) : (addr_q == ADDR_LAST);
      elem_next    = elem_q + 3'd1;
      start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   end

   // Sequencer: op within address, then address, then element, then drain
   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      addr_d  = addr_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               elem_d  = ELEM_M0;
               addr_d  = '0;
               op_d    = 1'b0;
            end
         end
         ST_RUN: begin
            if (!last_op) begin
               op_d = 1'b1;
            end else begin
               op_d = 1'b0;
               if (!terminal) begin
                  addr_d = elem_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
               end else if (elem_q == ELEM_M5) begin
                  state_d = ST_DRAIN;
               end else begin
                  elem_d = elem_next;
                  addr_d = ELEM_DOWN[elem_next] ? ADDR_LAST : '0;
               end
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         elem_q  <= '0;
         addr_q  <= '0;
         op_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
      end
   end

   // Outputs decode straight from state so reset releases the RAM immediately
   always_comb begin
      bist_mode  = running || (state_q == ST_DRAIN);
      busy       = bist_mode;
      done       = (state_q == ST_DONE);
      bist_we    = running && is_write;
      bist_re    = running && !is_write;
      bist_addr  = running ? addr_q : '0;
      bist_wdata = bist_we ? {DATA_WIDTH{ELEM_WRITE_BG[elem_q]}} : '0;
   end

   bist_response_checker #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_checker (
      .clk         (clk),
      .rst         (rst),
      .clear       (start_accept),
      .rd_valid    (bist_re),
      .rd_expected ({DATA_WIDTH{ELEM_READ_BG[elem_q]}}),
      .rd_addr     (addr_q),
      .rd_elem     (elem_q),
      .ram_rdata   (ram_rdata),
      .fail        (fail),
      .fail_addr   (fail_addr),
      .fail_elem   (fail_elem)
   );

endmodule

// File: tb/tb_bist_march_generator.sv
// Self-checking bench for bist_march_generator with an 8-word RAM model, an
// op-by-op scoreboard of the March C- sequence and a table of run scenarios.
module tb_bist_march_generator;

   localparam int AW = 3;
   localparam int DW = 8;
   localparam int NW = 8;
   localparam int RUN_DONE = 10 * NW + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] ram_rdata;
   logic          bist_mode;
   logic [AW-1:0] bist_addr;
   logic [DW-1:0] bist_wdata;
   logic          bist_we;
   logic          bist_re;
   logic          busy;
   logic          done;
   logic          fail;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_elem;

   logic          fault_en;
   logic [DW-1:0] mem [NW];

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic          we;
      logic          re;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } op_t;

   op_t sb_q[$];

   typedef struct {
      string name;
      bit    fault;
      int    repulse_at;
      int    rst_at;
      int    exp_done;
      bit    exp_fail;
      int    exp_fail_addr;
      int    exp_fail_elem;
   } vec_t;

   vec_t vecs[4];

   always #5 clk = ~clk;

   bist_march_generator #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ram_rdata  (ram_rdata),
      .bist_mode  (bist_mode),
      .bist_addr  (bist_addr),
      .bist_wdata (bist_wdata),
      .bist_we    (bist_we),
      .bist_re    (bist_re),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .fail_addr  (fail_addr),
      .fail_elem  (fail_elem)
   );

   // RAM model: synchronous write, registered read, optional stuck-at-1 on bit 0 of word 5
   always @(posedge clk) begin
      if (bist_we) mem[bist_addr] <= bist_wdata;
      if (bist_re) ram_rdata <= mem[bist_addr] | ((fault_en && bist_addr == 3'd5) ? 8'h01 : 8'h00);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Expected March C- op stream, derived element by element
   task automatic build_expected();
      int n_ops    [6] = '{1, 2, 2, 2, 2, 1};
      bit down     [6] = '{0, 0, 0, 1, 1, 0};
      bit first_wr [6] = '{1, 0, 0, 0, 0, 0};
      bit wr_val   [6] = '{0, 1, 0, 1, 0, 0};
      sb_q.delete();
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < NW; i++) begin
            int a;
            a = down[e] ? (NW - 1 - i) : i;
            for (int o = 0; o < n_ops[e]; o++) begin
               op_t t;
               logic w;
               w       = first_wr[e] || (o == 1);
               t.we    = w;
               t.re    = !w;
               t.addr  = a[AW-1:0];
               t.wdata = w ? {DW{wr_val[e]}} : '0;
               sb_q.push_back(t);
            end
         end
      end
   endtask

   // Start a run at the next edge and follow it op by op until done (or reset/timeout)
   task automatic applyStimulus(input vec_t v);
      int  rel = 0;
      int  done_rel = 0;
      int  writes = 0;
      int  reads = 0;
      int  mode_bad = 0;
      int  both = 0;
      int  extra = 0;
      op_t got;
      op_t exp;
      fault_en = v.fault;
      build_expected();
      start = 1'b1;
      while (done_rel == 0 && rel < 200) begin
         @(negedge clk);
         rel++;
         start = (v.repulse_at != 0) && (rel == v.repulse_at);
         if (rel == 1)
            checkOutput($sformatf("%s fail_cleared", v.name), 32'({fail, fail_addr, fail_elem}), 32'd0);
         if (v.rst_at != 0 && rel == v.rst_at + 1) begin
            checkOutput($sformatf("%s rst_outputs", v.name),
                        32'({bist_mode, bist_we, bist_re, busy, done, fail, bist_addr, bist_wdata, fail_addr, fail_elem}),
                        32'd0);
            rst = 1'b0;
            sb_q.delete();
            return;
         end
         if (v.rst_at != 0 && rel == v.rst_at) rst = 1'b1;
         if (bist_we && bist_re) both++;
         if (bist_we) writes++;
         if (bist_re) reads++;
         if (bist_we || bist_re) begin
            got = {bist_we, bist_re, bist_addr, bist_wdata};
            if (sb_q.size() == 0) begin
               extra++;
            end else begin
               exp = sb_q.pop_front();
               checkOutput($sformatf("%s op@%0d", v.name, rel), 32'(got), 32'(exp));
            end
         end
         if (done) done_rel = rel;
         else if (!bist_mode || !busy) mode_bad++;
      end
      checkOutput($sformatf("%s done_cycle", v.name), 32'(done_rel), 32'(v.exp_done));
      checkOutput($sformatf("%s mode_window", v.name), 32'(mode_bad), 32'd0);
      checkOutput($sformatf("%s idle_in_done", v.name), 32'({bist_mode, busy, bist_we, bist_re}), 32'd0);
      checkOutput($sformatf("%s writes", v.name), 32'(writes), 32'd40);
      checkOutput($sformatf("%s reads", v.name), 32'(reads), 32'd40);
      checkOutput($sformatf("%s we_re_overlap", v.name), 32'(both), 32'd0);
      checkOutput($sformatf("%s ops_left", v.name), 32'(sb_q.size() + extra), 32'd0);
      checkOutput($sformatf("%s fail", v.name), 32'(fail), 32'(v.exp_fail));
      checkOutput($sformatf("%s fail_addr", v.name), 32'(fail_addr), 32'(v.exp_fail_addr));
      checkOutput($sformatf("%s fail_elem", v.name), 32'(fail_elem), 32'(v.exp_fail_elem));
   endtask

   // Main sequence: reset checks, table of full runs, then mid-run reset recovery
   initial begin
      vec_t rv;
      vecs[0] = '{"clean",         1'b0, 0,  0, RUN_DONE, 1'b0, 0, 0};
      vecs[1] = '{"stuck_at_1",    1'b1, 0,  0, RUN_DONE, 1'b1, 5, 1};
      vecs[2] = '{"restart_clear", 1'b0, 0,  0, RUN_DONE, 1'b0, 0, 0};
      vecs[3] = '{"start_busy",    1'b0, 10, 0, RUN_DONE, 1'b0, 0, 0};

      fault_en = 1'b0;
      rst      = 1'b1;
      start    = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs",
                  32'({bist_mode, bist_we, bist_re, busy, done, fail, bist_addr, bist_wdata, fail_addr, fail_elem}),
                  32'd0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checkOutput("reset_beats_start", 32'({busy, done, bist_mode}), 32'd0);

      for (int i = 0; i < 4; i++) begin
         $display("[TB] running %s", vecs[i].name);
         applyStimulus(vecs[i]);
      end

      $display("[TB] running mid-run reset");
      rv = '{"mid_reset", 1'b0, 0, 30, RUN_DONE, 1'b0, 0, 0};
      applyStimulus(rv);
      repeat (9) @(negedge clk);
      checkOutput("idle_after_reset", 32'({busy, done, bist_mode, fail}), 32'd0);
      rv = '{"after_reset", 1'b0, 0, 0, RUN_DONE, 1'b0, 0, 0};
      applyStimulus(rv);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bist_march_generator.md
Name: bist_march_generator

Overview:
- Upstream BIST engine for the RAM-BIST path.
- Generates March C- address, write-data and write/read strobes for the RAM; drives the select of the downstream address/data multiplexer (bist_mode) so BIST traffic replaces functional traffic.
- Compares RAM read data against the expected background and reports pass/fail with the first failing address.

Parameters:
ADDR_WIDTH, 9, RAM address width; N = 2**ADDR_WIDTH words; matches the 9-bit multiplexer width.
DATA_WIDTH, 8, RAM data width; backgrounds are all-0 and all-1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a test; sampled only in IDLE or DONE.
ram_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after bist_re.
bist_mode  output  1  mux select: 1 = BIST drives RAM, 0 = functional path.
bist_addr  output  ADDR_WIDTH  RAM address during BIST.
bist_wdata  output  DATA_WIDTH  RAM write data.
bist_we  output  1  write strobe.
bist_re  output  1  read strobe.
busy  output  1  high in RUN and DRAIN.
done  output  1  high in DONE until the next start or rst.
fail  output  1  sticky mismatch flag for the current run.
fail_addr  output  ADDR_WIDTH  address of the first mismatch.
fail_elem  output  3  March element index (0-5) of the first mismatch.

Behaviour:
- Reset (sync, rst=1 at a clock edge): state IDLE. All outputs are 0: bist_mode, bist_addr, bist_wdata, bist_we, bist_re, busy, done, fail, fail_addr, fail_elem. rst overrides start in the same cycle.
- March C- elements, in order:
  - M0 up(w0)
  - M1 up(r0,w1)
  - M2 up(r1,w0)
  - M3 down(r0,w1)
  - M4 down(r1,w0)
  - M5 up(r0)
  - "0" is all-zeros and "1" is all-ones.
- One RAM operation per cycle.
  - Within an element, all ops complete at one address before the address changes.
  - up runs addresses 0 to N-1; down runs N-1 to 0.
  - The element ends at the terminal address. The next element starts on the following cycle with its first address, with no idle cycle.
- FSM:
  - IDLE -> RUN on start.
  - RUN -> DRAIN after the last M5 read.
  - DRAIN -> DONE after one cycle.
  - DONE -> RUN on start.
- start while busy is ignored.
- In DONE, start clears fail, fail_addr and fail_elem and restarts the test.
- Timing: start sampled at edge k. The first op (M0 w0, addr 0) is presented at cycle k+1. 10N op cycles follow. done is visible from cycle k+10N+2.
- bist_mode = 1 and busy = 1 from cycle k+1 through the DRAIN cycle. bist_mode returns to 0 in DONE.
- bist_we and bist_re are mutually exclusive and both 0 outside RUN.
- bist_wdata is driven only with bist_we; it is 0 otherwise.
- Checker:
  - On each read, the expected value, address and element are registered.
  - The next cycle compares ram_rdata against the registered expected value.
  - On the first mismatch: fail goes to 1, and fail_addr/fail_elem are captured.
  - Later mismatches do not overwrite the captured values.
  - The test always runs to completion (no early abort).
- Reset mid-run: on the next edge all state returns to IDLE with outputs 0. bist_mode drops immediately, which hands the RAM back to the functional path. The in-flight compare is discarded.

Decomposition:
- Package bist_pkg holds:
  - Element indices M0-M5 (3-bit localparams).
  - Per-element direction, first-op and op-count tables.
  - FSM state encoding: IDLE, RUN, DRAIN, DONE.
  - The background constants.
- One sub-module, bist_response_checker, contains the expected/addr/elem pipeline register, the comparator and the sticky first-fail capture.
- Address up/down counting stays in the top module.

Test Plan:
- Fault-free RAM model, ADDR_WIDTH=3 (N=8), start pulse at edge k:
  - done rises at k+82.
  - fail=0.
  - Exactly 40 writes and 40 reads.
  - bist_mode high from k+1 through k+81.
- Same setup, M3 address trace: addresses run 7,7,6,6,...,0,0, alternating re then we; bist_wdata=8'hFF on every write.
- Stuck-at-1 on bit 0 at address 5: fail=1, fail_addr=5, fail_elem=1 (first M1 r0 read). The run still completes with done at k+82.
- rst asserted at k+30: outputs are all 0 at k+31. A new start at k+40 completes cleanly, with done at k+40+82.
- start re-pulsed at k+10 while busy: no effect, done still at k+82. A start in DONE after a failing run clears fail and fail_addr on restart.
